systolic_matmul_engine: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine for the coprocessor: computes C = A×B (N×N result, runtime inner dimension k_len) with built-in input skewing, a job-control FSM, and valid/ready streaming on both input and output. It supersedes the fixed 4×4, 8-bit array-plus-controller wrapper. It adds signed/unsigned mode, accumulate-across-jobs for tiled K, stall-tolerant feeding, and backpressured result drain.

---
 rtl/systolic_matmul_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_systolic_matmul_engine.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine
//
// Output-stationary N x N systolic matrix-multiply engine computing C = A x B
// for a runtime inner dimension k_len (0..KMAX). A arrives one column per beat
// (in_a) and B one row per beat (in_b). The operands are skewed on entry so
// that beat k meets at PE(i,j) on advance k+i+j. Each PE keeps its own
// accumulator. When the array has been flushed, the results drain one row of C
// per handshake.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             job request, sampled only while idle
//   k_len             inner dimension of the job, latched at start
//   signed_mode       1 = two's-complement operands, latched at start
//   acc_keep          1 = keep accumulators from the previous job (tiled K)
//   busy              engine is not idle
//   done              one-cycle pulse at job end
//   in_valid/in_ready input beat handshake (in_ready high throughout LOAD)
//   in_a              column k of A, a[i][k] at [i*DW +: DW]
//   in_b              row k of B, b[k][j] at [j*DW +: DW]
//   out_valid/out_ready result row handshake
//   out_row           row r of C, c[r][j] at [j*ACCW +: ACCW]
//   out_idx           row index r of out_row
module systolic_matmul_engine #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int KMAX = 16,
  localparam int ACCW = 2*DW + $clog2(KMAX),
  localparam int KW   = $clog2(KMAX+1),
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              signed_mode,
  input  logic              acc_keep,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_a,
  input  logic [N*DW-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*ACCW-1:0] out_row,
  output logic [IW-1:0]     out_idx
);

  // Phase counter: counts accepted beats in LOAD and cycles in FLUSH.
  localparam int CW = $clog2(KMAX + 2*N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_q;
  logic            signed_q;
  logic [CW-1:0]   cnt;

  logic            start_take;
  logic            advance;

  assign start_take = (state == IDLE) && start;
  // The whole array (skew chains and PEs) steps together on an advance:
  // every accepted beat in LOAD and every cycle of FLUSH.
  assign advance    = ((state == LOAD) && in_valid) || (state == FLUSH);

  // ---------------------------------------------------------------------------
  // Job-control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: state and outputs are sequential, so they take non-blocking
  // assignments; this keeps every reader seeing pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      signed_q  <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q      <= k_len;
            signed_q <= signed_mode;
            busy     <= 1'b1;
            cnt      <= '0;
            if (k_len != '0) begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end else if (N > 1) begin
              state <= FLUSH;
            end else begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            if (cnt == CW'(k_q) - CW'(1)) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              if (N > 1) begin
                state <= FLUSH;
              end else begin
                state     <= DRAIN;
                out_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        // 2N-2 zero-fed advances push the last beat through the far corner.
        FLUSH: begin
          if (cnt == CW'(2*N - 3)) begin
            cnt       <= '0;
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_idx == IW'(N - 1)) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand feed and input skew
  // ---------------------------------------------------------------------------
  logic [DW-1:0] feed_a [N];
  logic [DW-1:0] feed_b [N];
  logic [DW-1:0] a_skew [N];
  logic [DW-1:0] b_skew [N];

  // Outside LOAD (i.e. in FLUSH) the array is fed zeros.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_b[i] = '0;
      if (state == LOAD) begin
        feed_a[i] = in_a[i*DW +: DW];
        feed_b[i] = in_b[i*DW +: DW];
      end
    end
  end

  // Row i of A and column j of B are delayed by i resp. j advances.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_skew[i] = feed_a[i];
      assign b_skew[i] = feed_b[i];
    end else begin : g_delay
      logic [DW-1:0] sr_a [i];
      logic [DW-1:0] sr_b [i];
      // NOTE: these register arrays are array state, not a RAM, so they are
      // reset and cleared at job start like any other operand register.
      always_ff @(posedge clk) begin
        if (rst || start_take) begin
          for (int d = 0; d < i; d++) begin
            sr_a[d] <= '0;
            sr_b[d] <= '0;
          end
        end else if (advance) begin
          sr_a[0] <= feed_a[i];
          sr_b[0] <= feed_b[i];
          for (int d = 1; d < i; d++) begin
            sr_a[d] <= sr_a[d-1];
            sr_b[d] <= sr_b[d-1];
          end
        end
      end
      assign a_skew[i] = sr_a[i-1];
      assign b_skew[i] = sr_b[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Processing elements
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   a_reg [N][N];
  logic [DW-1:0]   b_reg [N][N];
  logic [ACCW-1:0] acc   [N][N];
  logic [DW-1:0]   a_in  [N][N];
  logic [DW-1:0]   b_in  [N][N];
  logic [ACCW-1:0] prod  [N][N];

  // Both operands are sign- or zero-extended to ACCW before multiplying. The
  // low ACCW bits of that product equal the true product modulo 2^ACCW, which
  // is exactly what the wrapping accumulator needs.
  function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic          sgn);
    logic [ACCW-1:0] ax;
    logic [ACCW-1:0] bx;
    ax = {{(ACCW-DW){sgn & a[DW-1]}}, a};
    bx = {{(ACCW-DW){sgn & b[DW-1]}}, b};
    return ax * bx;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = a_skew[i];
      end else begin : g_a_chain
        assign a_in[i][j] = a_reg[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = b_skew[j];
      end else begin : g_b_chain
        assign b_in[i][j] = b_reg[i-1][j];
      end
      assign prod[i][j] = mul_ext(a_in[i][j], b_in[i][j], signed_q);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end else if (start_take) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          // Tiled K: partial sums survive into the next job when requested.
          if (!acc_keep) acc[i][j] <= '0;
        end else if (advance) begin
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
          acc[i][j]   <= acc[i][j] + prod[i][j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result drain: accumulators are frozen in DRAIN, so the selected row stays
  // stable for as long as the consumer stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*ACCW +: ACCW] = acc[out_idx][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Self-checking bench for systolic_matmul_engine (N=4, DW=8, KMAX=16).
// Expected results come from a plain matrix-multiply reference model with
// modulo-2^ACCW accumulation; job timing is checked against cycle formulas.
`timescale 1ns/1ps
module tb_systolic_matmul_engine;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KMAX = 16;
  localparam int ACCW = 2*DW + $clog2(KMAX);
  localparam int KW   = $clog2(KMAX+1);
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst, start, signed_mode, acc_keep, in_valid, out_ready;
  logic [KW-1:0]     k_len;
  logic              busy, done, in_ready, out_valid;
  logic [N*DW-1:0]   in_a, in_b;
  logic [N*ACCW-1:0] out_row;
  logic [IW-1:0]     out_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_matmul_engine #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .acc_keep(acc_keep), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx)
  );

  // Operand matrices and reference model
  logic [DW-1:0]     ma [N][KMAX];   // A[i][k]
  logic [DW-1:0]     mb [KMAX][N];   // B[k][j]
  logic [ACCW-1:0]   model_c [N][N];

  // Observations collected by run_job
  logic [N*ACCW-1:0] got_row [N];
  int                got_order [N];
  int                done_cyc, first_ov_cyc, idle_beats;
  bit                ready_drop, stall_bad;

  // Stimulus knobs
  int valid_mode;    // 0 continuous, 1 every other cycle, 2 random
  int stall_idx, stall_len;
  bit start_noise;

  task automatic model_job(input int k, input bit sgn, input bit keep);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!keep) model_c[i][j] = '0;
        for (int kk = 0; kk < k; kk++) begin
          int av, bv;
          if (sgn) begin
            av = $signed(ma[i][kk]);
            bv = $signed(mb[kk][j]);
          end else begin
            av = ma[i][kk];
            bv = mb[kk][j];
          end
          model_c[i][j] = model_c[i][j] + ACCW'(av * bv);
        end
      end
    end
  endtask

  function automatic logic [N*ACCW-1:0] exp_row(input int r);
    logic [N*ACCW-1:0] v;
    for (int j = 0; j < N; j++) v[j*ACCW +: ACCW] = model_c[r][j];
    return v;
  endfunction

  task automatic set_knobs(input int vm, input int s_idx, input int s_len, input bit noise);
    valid_mode = vm; stall_idx = s_idx; stall_len = s_len; start_noise = noise;
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) ma[i][k] = (i == k) ? DW'(1) : DW'(0);
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) mb[k][j] = (k < N) ? DW'(k*N + j + 1) : DW'(0);
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = av;
        mb[k][i] = bv;
      end
  endtask

  // Drives one job from start to done. Cycle 1 is the first cycle after the
  // edge that samples start. Returns at the falling edge of the done cycle.
  task automatic run_job(input int k, input bit sgn, input bit keep);
    int cyc, beat, rows, stall_left, guard;
    bit was_stalled;
    logic [N*ACCW-1:0] held_row;
    logic [IW-1:0] held_idx;
    beat = 0; rows = 0; stall_left = stall_len; was_stalled = 0;
    held_row = '0; held_idx = '0;
    ready_drop = 0; stall_bad = 0; done_cyc = -1; first_ov_cyc = -1; idle_beats = 0;
    for (int r = 0; r < N; r++) begin
      got_row[r] = 'x;
      got_order[r] = -1;
    end
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); signed_mode = sgn; acc_keep = keep;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    cyc = 0; guard = 0;
    while (done_cyc < 0 && guard < 600) begin
      @(negedge clk);
      cyc++; guard++;
      if (done) begin
        done_cyc = cyc;
      end else begin
        // start and job parameters while busy must be ignored
        start       = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k_len       = start_noise ? KW'($urandom_range(0, KMAX)) : KW'(k);
        signed_mode = start_noise ? 1'($urandom_range(0, 1)) : sgn;
        acc_keep    = start_noise ? 1'($urandom_range(0, 1)) : keep;
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (was_stalled && (out_row !== held_row || out_idx !== held_idx || out_valid !== 1'b1))
          stall_bad = 1;
        if (beat < k && !in_ready) ready_drop = 1;
        in_a = (N*DW)'($urandom);
        in_b = (N*DW)'($urandom);
        if (in_ready && beat < k) begin
          case (valid_mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
          endcase
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              in_a[i*DW +: DW] = ma[i][beat];
              in_b[i*DW +: DW] = mb[beat][i];
            end
            beat++;
          end else begin
            idle_beats++;
          end
        end else begin
          // garbage beats outside LOAD must not disturb the array
          in_valid = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        if (out_valid) begin
          if (stall_left > 0 && out_idx == IW'(stall_idx)) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (rows < N) begin
            got_row[rows] = out_row;
            got_order[rows] = int'(out_idx);
            rows++;
          end
        end
        was_stalled = out_valid && !out_ready;
        held_row = out_row;
        held_idx = out_idx;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_keep = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, in_ready, out_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b, want 0000", {busy, done, in_ready, out_valid});
    end
    n_cmp++;
    if (out_row !== '0) begin
      n_err++; $display("FAIL reset_out_row: got %h, want 0", out_row);
    end
    n_cmp++;
    if (out_idx !== '0) begin
      n_err++; $display("FAIL reset_out_idx: got %0d, want 0", out_idx);
    end
    rst = 1'b0;
    model_job(0, 1'b0, 1'b0);
  endtask

  task automatic test_identity();
    set_knobs(0, 0, 0, 0);
    load_identity();
    model_job(4, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) begin
      n_cmp++;
      if (got_row[r] !== exp_row(r) || got_order[r] != r) begin
        n_err++; $display("FAIL identity_row%0d: got idx %0d row %h, want idx %0d row %h",
                          r, got_order[r], got_row[r], r, exp_row(r));
      end
    end
    n_cmp++;
    if (got_row[2][3*ACCW +: ACCW] !== ACCW'(12)) begin
      n_err++; $display("FAIL identity_c23: got %0d, want 12", got_row[2][3*ACCW +: ACCW]);
    end
    n_cmp++;
    if (first_ov_cyc != 11) begin
      n_err++; $display("FAIL identity_first_valid: got cycle %0d, want 11", first_ov_cyc);
    end
    n_cmp++;
    if (done_cyc != 15) begin
      n_err++; $display("FAIL identity_done: got cycle %0d, want 15", done_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL identity_idle_after: got busy %b done %b, want 0 0", busy, done);
    end
  endtask

  task automatic test_signed();
    set_knobs(0, 0, 0, 0);
    load_const(8'hFF, 8'h02);
    for (int m = 0; m < 2; m++) begin
      bit sgn;
      logic [ACCW-1:0] want_c;
      sgn = (m == 0);
      want_c = sgn ? 20'hFFFF8 : 20'd2040;
      model_job(4, sgn, 1'b0);
      run_job(4, sgn, 1'b0);
      for (int r = 0; r < N; r++) begin
        n_cmp++;
        if (got_row[r] !== exp_row(r)) begin
          n_err++; $display("FAIL signed%0d_row%0d: got %h, want %h", sgn, r, got_row[r], exp_row(r));
        end
      end
      n_cmp++;
      if (got_row[3][0 +: ACCW] !== want_c) begin
        n_err++; $display("FAIL signed%0d_c30: got %h, want %h", sgn, got_row[3][0 +: ACCW], want_c);
      end
    end
  endtask

  task automatic test_valid_toggle();
    set_knobs(1, 0, 0, 0);
    load_identity();
    model_job(4, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) begin
      n_cmp++;
      if (got_row[r] !== exp_row(r) || got_order[r] != r) begin
        n_err++; $display("FAIL toggle_row%0d: got idx %0d row %h, want idx %0d row %h",
                          r, got_order[r], got_row[r], r, exp_row(r));
      end
    end
    n_cmp++;
    if (done_cyc != 15 + idle_beats || idle_beats == 0) begin
      n_err++; $display("FAIL toggle_done: got cycle %0d, want %0d (idle beats %0d)",
                        done_cyc, 15 + idle_beats, idle_beats);
    end
    n_cmp++;
    if (ready_drop) begin
      n_err++; $display("FAIL toggle_in_ready: in_ready dropped during LOAD, want held 1");
    end
  endtask

  task automatic test_out_stall();
    set_knobs(0, 1, 3, 0);
    load_identity();
    model_job(4, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) begin
      n_cmp++;
      if (got_row[r] !== exp_row(r) || got_order[r] != r) begin
        n_err++; $display("FAIL stall_row%0d: got idx %0d row %h, want idx %0d row %h",
                          r, got_order[r], got_row[r], r, exp_row(r));
      end
    end
    n_cmp++;
    if (stall_bad) begin
      n_err++; $display("FAIL stall_hold: out_row/out_idx changed during stall, want stable");
    end
    n_cmp++;
    if (done_cyc != 18) begin
      n_err++; $display("FAIL stall_done: got cycle %0d, want 18", done_cyc);
    end
  endtask

  task automatic test_acc_keep();
    int    ks   [4] = '{4, 4, 0, 0};
    bit    kp   [4] = '{0, 1, 1, 0};
    int    want [4] = '{4, 8, 8, 0};
    int    wdone[4] = '{15, 15, 11, 11};
    set_knobs(0, 0, 0, 0);
    load_const(8'h01, 8'h01);
    for (int s = 0; s < 4; s++) begin
      model_job(ks[s], 1'b0, kp[s]);
      run_job(ks[s], 1'b0, kp[s]);
      for (int r = 0; r < N; r++) begin
        n_cmp++;
        if (got_row[r] !== exp_row(r) || got_row[r][ACCW-1:0] !== ACCW'(want[s])) begin
          n_err++; $display("FAIL keep%0d_row%0d: got %h, want %h", s, r, got_row[r], exp_row(r));
        end
      end
      n_cmp++;
      if (done_cyc != wdone[s]) begin
        n_err++; $display("FAIL keep%0d_done: got cycle %0d, want %0d", s, done_cyc, wdone[s]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int done_seen;
    load_identity();
    @(negedge clk);
    start = 1'b1; k_len = KW'(4); signed_mode = 1'b0; acc_keep = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_a = (N*DW)'($urandom);
      in_b = (N*DW)'($urandom);
    end
    // cycle 6 is inside FLUSH for k_len=4
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL midjob_flush: got busy %b in_ready %b, want 1 0", busy, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, in_ready, done} !== 4'b0000) begin
      n_err++; $display("FAIL midjob_abort: got busy/out_valid/in_ready/done %b, want 0000",
                        {busy, out_valid, in_ready, done});
    end
    rst = 1'b0; in_valid = 1'b0;
    model_job(0, 1'b0, 1'b0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++; $display("FAIL midjob_no_done: got %0d done pulses, want 0", done_seen);
    end
    // next job with start and job inputs toggling while busy
    set_knobs(0, 0, 0, 1);
    model_job(4, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) begin
      n_cmp++;
      if (got_row[r] !== exp_row(r) || got_order[r] != r) begin
        n_err++; $display("FAIL after_reset_row%0d: got idx %0d row %h, want idx %0d row %h",
                          r, got_order[r], got_row[r], r, exp_row(r));
      end
    end
    n_cmp++;
    if (done_cyc != 15) begin
      n_err++; $display("FAIL after_reset_done: got cycle %0d, want 15", done_cyc);
    end
  endtask

  task automatic test_random_b2b();
    set_knobs(2, 0, 0, 0);
    for (int t = 0; t < 8; t++) begin
      int k;
      bit sgn, keep;
      k    = (t == 0) ? KMAX : $urandom_range(0, KMAX);
      sgn  = 1'($urandom_range(0, 1));
      keep = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < KMAX; kk++) begin
          ma[i][kk] = DW'($urandom);
          mb[kk][i] = DW'($urandom);
        end
      stall_idx = $urandom_range(0, N-1);
      stall_len = $urandom_range(0, 2);
      model_job(k, sgn, keep);
      // called immediately after the previous done: start lands in IDLE
      run_job(k, sgn, keep);
      for (int r = 0; r < N; r++) begin
        n_cmp++;
        if (got_row[r] !== exp_row(r) || got_order[r] != r) begin
          n_err++; $display("FAIL rand%0d_row%0d: got idx %0d row %h, want idx %0d row %h",
                            t, r, got_order[r], got_row[r], r, exp_row(r));
        end
      end
      n_cmp++;
      if (done_cyc != k + 3*N - 1 + idle_beats + stall_len) begin
        n_err++; $display("FAIL rand%0d_done: got cycle %0d, want %0d", t, done_cyc,
                          k + 3*N - 1 + idle_beats + stall_len);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; acc_keep = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    set_knobs(0, 0, 0, 0);
    test_reset();
    test_identity();
    test_signed();
    test_valid_toggle();
    test_out_stall();
    test_acc_keep();
    test_reset_midjob();
    test_random_b2b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
